// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_1r1w_masked memory model.
package sram_pkg;

    typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    localparam int MERGE_MAX_W = 1024;
    typedef logic [MERGE_MAX_W-1:0] merge_word_t;

    // Bit j comes from new_word when its lane (j / gran) is enabled in mask, else from old_word.
    function automatic merge_word_t merge_lanes(input merge_word_t old_word,
                                                input merge_word_t new_word,
                                                input merge_word_t mask,
                                                input int          gran);
        merge_word_t res;
        res = old_word;
        for (int j = 0; j < MERGE_MAX_W; j++) begin
            if (gran > 0 && mask[j / gran]) begin
                res[j] = new_word[j];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// Read-data pipeline: one register stage per cycle of read latency; data registers
// load only on a valid beat so the output holds between reads.
module sram_read_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_valid;
        logic [DATA_WIDTH-1:0] s2_data;

        always_ff @(posedge clk) begin
            if (!rst_b) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign out_valid = s2_valid;
        assign out_data  = s2_data;
    end else begin : g_lat1
        assign out_valid = s1_valid;
        assign out_data  = s1_data;
    end

endmodule

// File: rtl/sram_1r1w_masked.sv
// Simple-dual-port SRAM with lane write mask, 1-2 cycle read latency and selectable read-during-write.
// Define SRAM_INIT_CLEAR_EN to compile in a post-reset zero-fill sweep that holds init_busy high.
module sram_1r1w_masked
    import sram_pkg::*;
#(
    parameter int        DATA_WIDTH   = 32,
    parameter int        DEPTH        = 64,
    parameter int        MASK_GRAN    = 8,
    parameter int        READ_LATENCY = 1,
    parameter rdw_mode_e RDW_MODE     = RDW_NEW,
    localparam int       NLANES       = DATA_WIDTH / MASK_GRAN,
    localparam int       AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  a_we,
    input  logic [AW-1:0]         a_addr,
    input  logic [NLANES-1:0]     a_wmask,
    input  logic [DATA_WIDTH-1:0] a_data_in,
    input  logic                  b_re,
    input  logic [AW-1:0]         b_addr,
    output logic [DATA_WIDTH-1:0] b_data_out,
    output logic                  b_rvalid,
    output logic                  init_busy
);

    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
        $error("sram_1r1w_masked: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % MASK_GRAN != 0) begin : g_bad_gran
        $error("sram_1r1w_masked: DATA_WIDTH must be a multiple of MASK_GRAN");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  a_in_range;
    logic                  b_in_range;
    logic                  user_wr;
    logic                  rd_launch;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [NLANES-1:0]     wr_mask;
    logic [DATA_WIDTH-1:0] wr_data;

    assign a_in_range = int'(a_addr) < DEPTH;
    assign b_in_range = int'(b_addr) < DEPTH;
    assign user_wr    = a_we && !init_busy && a_in_range && (|a_wmask);
    assign rd_launch  = b_re && !init_busy;

`ifdef SRAM_INIT_CLEAR_EN
    typedef enum logic {CLEAR, READY} clr_state_e;

    clr_state_e    state;
    clr_state_e    state_next;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] clr_cnt_next;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        init_busy    = 1'b0;
        if (state == CLEAR) begin
            init_busy = 1'b1;
            if (int'(clr_cnt) == DEPTH - 1) begin
                state_next   = READY;
                clr_cnt_next = '0;
            end else begin
                clr_cnt_next = clr_cnt + AW'(1);
            end
        end
    end
`else
    assign init_busy = 1'b0;
`endif

    // The clear sweep borrows the write port; user writes are already blocked by init_busy.
    always_comb begin
        wr_en   = user_wr;
        wr_addr = a_addr;
        wr_mask = a_wmask;
        wr_data = a_data_in;
`ifdef SRAM_INIT_CLEAR_EN
        if (state == CLEAR) begin
            wr_en   = rst_b;
            wr_addr = clr_cnt;
            wr_mask = '1;
            wr_data = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < NLANES; l++) begin
                if (wr_mask[l]) begin
                    mem[wr_addr][l*MASK_GRAN +: MASK_GRAN] <= wr_data[l*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // The array read is pre-write, which is already RDW_OLD; RDW_NEW bypasses the enabled lanes.
    always_comb begin
        rd_word = '0;
        if (b_in_range) begin
            rd_word = mem[b_addr];
            if (RDW_MODE == RDW_NEW && user_wr && a_addr == b_addr) begin
                rd_word = DATA_WIDTH'(merge_lanes(merge_word_t'(mem[b_addr]),
                                                  merge_word_t'(a_data_in),
                                                  merge_word_t'(a_wmask),
                                                  MASK_GRAN));
            end
        end
    end

    sram_read_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_read_pipe (
        .clk      (clk),
        .rst_b    (rst_b),
        .in_valid (rd_launch),
        .in_data  (rd_word),
        .out_valid(b_rvalid),
        .out_data (b_data_out)
    );

endmodule

// File: tb/tb_sram_1r1w_masked.sv
// Self-checking bench for sram_1r1w_masked: directed vector table, corner sequences and
// randomized traffic checked cycle by cycle against a behavioural memory model.
module tb_sram_1r1w_masked;
    import sram_pkg::*;

    localparam int        DW    = 32;
    localparam int        DEPTH = 40;
    localparam int        GRAN  = 8;
    localparam int        LAT   = 2;
    localparam rdw_mode_e MODE  = RDW_NEW;
    localparam int        NL    = DW / GRAN;
    localparam int        AW    = $clog2(DEPTH);
`ifdef SRAM_INIT_CLEAR_EN
    localparam bit        CLEAR_EN = 1'b1;
`else
    localparam bit        CLEAR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_b;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [NL-1:0] a_wmask;
    logic [DW-1:0] a_data_in;
    logic          b_re;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data_out;
    logic          b_rvalid;
    logic          init_busy;

    sram_1r1w_masked #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .MASK_GRAN   (GRAN),
        .READ_LATENCY(LAT),
        .RDW_MODE    (MODE)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wmask   (a_wmask),
        .a_data_in (a_data_in),
        .b_re      (b_re),
        .b_addr    (b_addr),
        .b_data_out(b_data_out),
        .b_rvalid  (b_rvalid),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int busy_left   = 0;

    // Model: word contents plus a mask of bits whose value is known.
    logic [DW-1:0] model_mem  [DEPTH];
    logic [DW-1:0] known_bits [DEPTH];
    logic [DW-1:0] last_out;
    logic [DW-1:0] last_care;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [DW-1:0] care;
    } pend_t;
    pend_t pend_q[$];

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [NL-1:0] mask;
        logic [DW-1:0] wdata;
        logic          re;
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp_new;
        logic [DW-1:0] exp_old;
    } vec_t;
    vec_t tbl [15];

    function automatic logic [DW-1:0] lane_bits(input logic [NL-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NL; i++) begin
            if (m[i]) r = r | ({{(DW-GRAN){1'b0}}, {GRAN{1'b1}}} << (i * GRAN));
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected, input logic [DW-1:0] care);
        vectors++;
        if (((actual ^ expected) & care) != '0) begin
            miscompares++;
            $display("[TB] FAIL %s @cycle %0d: got %h, expected %h (care %h)",
                     name, cycle, actual, expected, care);
        end
    endtask

    // Expected read result from the memory rules, evaluated before this cycle's write lands.
    task automatic modelRead(input logic we, input logic [AW-1:0] waddr, input logic [NL-1:0] mask,
                             input logic [DW-1:0] wdata, input logic [AW-1:0] raddr,
                             output logic [DW-1:0] d, output logic [DW-1:0] care);
        logic [DW-1:0] m;
        m = lane_bits(mask);
        if (int'(raddr) >= DEPTH) begin
            d    = '0;
            care = '1;
        end else if (MODE == RDW_NEW && we && waddr == raddr) begin
            d    = (model_mem[raddr] & ~m) | (wdata & m);
            care = known_bits[raddr] | m;
        end else begin
            d    = model_mem[raddr];
            care = known_bits[raddr];
        end
    endtask

    task automatic sampleOutputs();
        pend_t p;
        checkOutput("init_busy", DW'(init_busy), DW'(busy_left > 0), '1);
        if (pend_q.size() > 0 && pend_q[0].due == cycle) begin
            p = pend_q.pop_front();
            checkOutput("b_rvalid pulse", DW'(b_rvalid), DW'(1'b1), '1);
            checkOutput("b_data_out", b_data_out, p.data, p.care);
            last_out  = p.data;
            last_care = p.care;
        end else begin
            checkOutput("b_rvalid idle", DW'(b_rvalid), '0, '1);
            checkOutput("b_data_out hold", b_data_out, last_out, last_care);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] waddr, input logic [NL-1:0] mask,
                                 input logic [DW-1:0] wdata, input logic re, input logic [AW-1:0] raddr,
                                 input bit use_fixed, input logic [DW-1:0] fixed_exp);
        bit            busy;
        pend_t         p;
        logic [DW-1:0] m;
        busy      = busy_left > 0;
        a_we      = we;
        a_addr    = waddr;
        a_wmask   = mask;
        a_data_in = wdata;
        b_re      = re;
        b_addr    = raddr;
        if (re && !busy) begin
            modelRead(we, waddr, mask, wdata, raddr, p.data, p.care);
            if (use_fixed) begin
                p.data = fixed_exp;
                p.care = '1;
            end
            p.due = cycle + LAT;
            pend_q.push_back(p);
        end
        if (we && !busy && int'(waddr) < DEPTH) begin
            m = lane_bits(mask);
            model_mem[waddr]  = (model_mem[waddr] & ~m) | (wdata & m);
            known_bits[waddr] = known_bits[waddr] | m;
        end
        @(posedge clk);
        cycle++;
        if (busy_left > 0) busy_left--;
        #1;
        sampleOutputs();
    endtask

    task automatic idleTick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic readTick(input int addr);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(addr), 1'b0, '0);
    endtask

    // Holds rst_b low for n edges with the current inputs; everything in flight is lost.
    task automatic applyReset(input int n);
        rst_b = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cycle++;
        end
        #1;
        pend_q.delete();
        last_out  = '0;
        last_care = '1;
        busy_left = CLEAR_EN ? DEPTH : 0;
        if (CLEAR_EN) begin
            for (int i = 0; i < DEPTH; i++) begin
                model_mem[i]  = '0;
                known_bits[i] = '1;
            end
        end
        checkOutput("reset b_rvalid", DW'(b_rvalid), '0, '1);
        checkOutput("reset b_data_out", b_data_out, '0, '1);
        checkOutput("reset init_busy", DW'(init_busy), DW'(CLEAR_EN), '1);
        rst_b = 1'b1;
    endtask

    task automatic randomCycle();
        logic          we, re;
        logic [AW-1:0] wa, ra;
        logic [NL-1:0] m;
        logic [DW-1:0] d;
        wa = AW'($urandom_range(0, (1 << AW) - 1));
        ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, (1 << AW) - 1));
        we = 1'($urandom_range(0, 1));
        re = 1'($urandom_range(0, 1));
        m  = NL'($urandom);
        d  = $urandom;
        applyStimulus(we, wa, m, d, re, ra, 1'b0, '0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]  = '0;
            known_bits[i] = '0;
        end
        last_out  = '0;
        last_care = '1;
        rst_b     = 1'b0;
        a_we      = 1'b0;
        a_addr    = '0;
        a_wmask   = '0;
        a_data_in = '0;
        b_re      = 1'b0;
        b_addr    = '0;

        //                 we    waddr  mask   wdata          re    raddr  exp_new        exp_old
        tbl[0]  = '{1'b1, 6'd5,  4'hF, 32'h11223344, 1'b0, 6'd0,  32'h0,        32'h0};
        tbl[1]  = '{1'b1, 6'd5,  4'h5, 32'hAABBCCDD, 1'b0, 6'd0,  32'h0,        32'h0};
        tbl[2]  = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd5,  32'h11BB33DD, 32'h11BB33DD};
        tbl[3]  = '{1'b1, 6'd3,  4'hF, 32'h0,        1'b0, 6'd0,  32'h0,        32'h0};
        tbl[4]  = '{1'b1, 6'd3,  4'h3, 32'hFFFFFFFF, 1'b1, 6'd3,  32'h0000FFFF, 32'h00000000};
        tbl[5]  = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd3,  32'h0000FFFF, 32'h0000FFFF};
        tbl[6]  = '{1'b1, 6'd13, 4'hF, 32'h13131313, 1'b0, 6'd0,  32'h0,        32'h0};
        tbl[7]  = '{1'b1, 6'd45, 4'hF, 32'hDEADBEEF, 1'b1, 6'd45, 32'h0,        32'h0};
        tbl[8]  = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd45, 32'h0,        32'h0};
        tbl[9]  = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd13, 32'h13131313, 32'h13131313};
        tbl[10] = '{1'b1, 6'd7,  4'hF, 32'h07070707, 1'b0, 6'd0,  32'h0,        32'h0};
        tbl[11] = '{1'b1, 6'd7,  4'h0, 32'hFFFFFFFF, 1'b1, 6'd7,  32'h07070707, 32'h07070707};
        tbl[12] = '{1'b1, 6'd39, 4'hF, 32'h39393939, 1'b0, 6'd0,  32'h0,        32'h0};
        tbl[13] = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd39, 32'h39393939, 32'h39393939};
        tbl[14] = '{1'b1, 6'd39, 4'h8, 32'h00FFFFFF, 1'b1, 6'd39, 32'h00393939, 32'h39393939};

        applyReset(3);

        // A write right after reset lands in the default build and is ignored during a clear sweep.
        applyStimulus(1'b1, AW'(2), '1, 32'hFFFFFFFF, 1'b0, '0, 1'b0, '0);
        while (busy_left > 0) idleTick();
        for (int i = 0; i < DEPTH; i++) readTick(i);
        for (int i = 0; i < LAT; i++) idleTick();

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, AW'(i), '1, $urandom, 1'b0, '0, 1'b0, '0);
        end

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].we, tbl[i].waddr, tbl[i].mask, tbl[i].wdata, tbl[i].re, tbl[i].raddr,
                          1'b1, (MODE == RDW_NEW) ? tbl[i].exp_new : tbl[i].exp_old);
        end
        for (int i = 0; i < LAT + 1; i++) idleTick();

        for (int i = 0; i < 8; i++) readTick(i);
        for (int i = 0; i < LAT + 1; i++) idleTick();

        for (int n = 0; n < 600; n++) randomCycle();
        for (int i = 0; i < LAT + 1; i++) idleTick();

        // One read launched, a second presented on the reset edge: neither may produce b_rvalid.
        readTick(1);
        b_re   = 1'b1;
        b_addr = AW'(2);
        applyReset(1);
        for (int i = 0; i < LAT + 2; i++) idleTick();
        while (busy_left > 0) idleTick();
        readTick(5);
        readTick(13);
        readTick(39);
        for (int i = 0; i < LAT + 1; i++) idleTick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_1r1w_masked.md
# sram_1r1w_masked

Parametrised simple-dual-port SRAM: one write port (A) with lane-granular write mask and one independent read port (B) with configurable read latency and deterministic read-during-write behaviour. It is the next-generation register-file/buffer macro model for the datapath generators. It replaces single-port, bit-masked, undefined-on-write memories wherever a producer and a consumer must access storage in the same cycle.

## Interface
Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of MASK_GRAN.
- DEPTH, 64: number of words; need not be a power of two.
- MASK_GRAN, 8: bits per write-mask lane; lane count NLANES = DATA_WIDTH/MASK_GRAN.
- READ_LATENCY, 1: cycles from read request to data; legal values 1 or 2.
- RDW_MODE, RDW_NEW: behaviour of a same-address read and write in the same cycle; RDW_OLD returns pre-write data, RDW_NEW returns post-write data.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_b  input  1  synchronous, active-low reset.
- a_we  input  1  write enable.
- a_addr  input  $clog2(DEPTH)  write address.
- a_wmask  input  NLANES  per-lane write enable; lane i covers bits [i*MASK_GRAN +: MASK_GRAN].
- a_data_in  input  DATA_WIDTH  write data.
- b_re  input  1  read request.
- b_addr  input  $clog2(DEPTH)  read address.
- b_data_out  output  DATA_WIDTH  read data.
- b_rvalid  output  1  high for one cycle when b_data_out carries data for a request.
- init_busy  output  1  high while the memory is unavailable (see Configuration).

## Operation
- Write: on a rising edge with a_we=1 and init_busy=0, every lane with a_wmask[i]=1 is updated; unmasked lanes are unchanged. a_wmask=0 is a no-op.
- Read: b_re=1 with init_busy=0 launches a read of b_addr. Reads are fully pipelined, one per cycle, with no back-pressure.
- Read-during-write, same address and same cycle:
  - RDW_OLD: the read returns the array contents before the write.
  - RDW_NEW: each lane returns a_data_in where a_wmask is set and the old contents elsewhere (per-lane merge).
- Different-address reads and writes are fully independent.
- Out-of-range address (addr >= DEPTH):
  - The write is dropped.
  - The read completes normally: b_rvalid is asserted and b_data_out=0.
- Requests issued while init_busy=1 are ignored; no b_rvalid is produced for them.
- Memory contents are not reset unless SRAM_INIT_CLEAR_EN is defined.

## Timing
- Read at edge t, then b_rvalid=1 and b_data_out valid at edge t+READ_LATENCY. With READ_LATENCY=2, the second stage is a pure output register.
- b_data_out holds its last value when b_rvalid=0.
- Writes are visible to a read launched on the next edge. Same-edge visibility is governed by RDW_MODE.
- Reset values, applied while rst_b=0:
  - b_rvalid=0 and b_data_out=0.
  - All pipeline valid bits cleared.
  - init_busy=1 if SRAM_INIT_CLEAR_EN is defined, else 0.
- Reset asserted mid-operation: in-flight reads are discarded and no b_rvalid is produced for them.

## Configuration
- SRAM_INIT_CLEAR_EN defined: a clear FSM is compiled in.
  - States: CLEAR then READY.
  - Reset enters CLEAR with the sweep counter at 0.
  - CLEAR writes zero to one address per cycle, 0 through DEPTH-1.
  - The FSM enters READY after DEPTH cycles; init_busy=1 exactly while in CLEAR.
  - A reset during CLEAR restarts the sweep at 0.
- SRAM_INIT_CLEAR_EN undefined: no FSM and no counter; init_busy is tied to 0 and contents are uninitialised after reset.

## Structure
- Shared package sram_pkg holds:
  - typedef enum rdw_mode_e {RDW_OLD, RDW_NEW}.
  - Lane-merge function merge_lanes(old, new, mask, gran).
  - Elaboration-check constants for legal READ_LATENCY values.
- One sub-module, sram_read_pipe: the valid/data pipeline parametrised by READ_LATENCY, with synchronous active-low reset of the valid bits and b_data_out.
- The array, write logic, RDW merge and clear FSM stay in the top module.

## Test plan
- Masked write: write addr 5, a_wmask=4'b0101, data 32'hAABBCCDD over 32'h11223344 -> read of 5 returns 32'h11BB33DD, with b_rvalid exactly READ_LATENCY cycles after b_re.
- Same-cycle read/write, addr 3, old 32'h0, write 32'hFFFF_FFFF with mask 4'b0011 -> RDW_NEW returns 32'h0000FFFF; RDW_OLD returns 32'h0.
- Back-to-back reads of addrs 0..7 with READ_LATENCY=2 -> eight consecutive b_rvalid pulses carrying data in issue order.
- DEPTH=40: write to addr 45, then read addr 45 -> returns 0 with b_rvalid=1, and addr 13 (45 mod 32) is unchanged.
- Reset asserted with two reads in flight -> b_rvalid stays 0 and b_data_out=0 after the reset edge.
- SRAM_INIT_CLEAR_EN with DEPTH=64 -> init_busy is high for exactly 64 cycles after reset release, a write issued during that window is ignored, and afterwards every address reads 0.
